button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 2: consecutive identical synchronized samples needed to accept a press or release; legal range 1..255.
REQ-002 Parameter LONG_PRESS_CYCLES, default 100: cycles in PRESSED before a long press is declared (1 s at 100 Hz); legal range 1..65535.
REQ-003 Parameter REPEAT_CYCLES, default 25: auto-repeat period while held; legal range 1..65535.
REQ-004 clockSignal  input  1  single clock (100 Hz system tick); all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 startOrStopRaw  input  1  raw asynchronous button, channel 0.
REQ-007 splitOrResetRaw  input  1  raw asynchronous button, channel 1.
REQ-008 modeInputRaw  input  1  raw asynchronous button, channel 2.
REQ-009 buttonLevel  output  3  debounced level per channel; bit index = channel number.
REQ-010 buttonPulse  output  3  one-cycle press-accepted pulse per channel.
REQ-011 longPulse  output  3  one-cycle long-press pulse per channel.
REQ-012 repeatPulse  output  3  one-cycle auto-repeat pulse per channel.

Function
REQ-013 Each channel SHALL pass its raw input through a two-flop synchronizer; only the second flop (sync2) feeds the FSM.
REQ-014 Channels SHALL be fully independent, each with its own FSM and counters; simultaneous presses on several channels SHALL each behave exactly as when pressed alone.
REQ-015 Per-channel FSM states SHALL be IDLE, PRESS_WAIT, PRESSED, HELD, RELEASE_WAIT.
REQ-016 IDLE: sync2=1 -> PRESS_WAIT with debounce count=1; if DEBOUNCE_CYCLES=1, go directly to PRESSED instead.
REQ-017 PRESS_WAIT: sync2=0 -> IDLE with no output; sync2=1 -> increment count; when the count reaches DEBOUNCE_CYCLES -> PRESSED.
REQ-018 On entry to PRESSED from IDLE/PRESS_WAIT, buttonPulse SHALL be high for exactly the following cycle, buttonLevel SHALL go high on the same edge, and the hold counter SHALL clear.
REQ-019 Latency: raw high before edge E, DEBOUNCE_CYCLES=2 -> buttonPulse and buttonLevel high between edges E+3 and E+4.
REQ-020 PRESSED: hold counter increments each cycle; on reaching LONG_PRESS_CYCLES -> HELD, longPulse high one cycle, repeat counter cleared.
REQ-021 HELD: repeat counter increments; on reaching REPEAT_CYCLES, repeatPulse high one cycle and counter reloads to 0; pulses recur every REPEAT_CYCLES cycles while held.
REQ-022 PRESSED/HELD with sync2=0 -> RELEASE_WAIT, debounce count=1; hold and repeat counters freeze.
REQ-023 RELEASE_WAIT: sync2=1 -> return to the originating state (PRESSED or HELD), counters resume, no new buttonPulse; DEBOUNCE_CYCLES consecutive lows -> IDLE, buttonLevel low on that edge.
REQ-024 buttonLevel SHALL stay high throughout PRESSED, HELD and RELEASE_WAIT.
REQ-025 Debounce counters SHALL be 8 bits; hold and repeat counters 16 bits; no counter SHALL wrap past its terminal value.
REQ-026 buttonPulse, longPulse and repeatPulse SHALL never be high in the same cycle on one channel; a glitch shorter than DEBOUNCE_CYCLES samples SHALL produce no output.

Reset
REQ-027 With reset high at a rising edge, all synchronizer flops, counters and outputs SHALL be 0 and every FSM SHALL be IDLE on the following cycle.
REQ-028 Reset asserted mid-press SHALL abort without emitting any pulse; a button still held after reset deasserts SHALL be re-debounced from IDLE and produce a fresh buttonPulse.
REQ-029 Reset SHALL take priority over every other input in the same cycle.

Verification
REQ-030 Raw ch0 high from edge 10, defaults -> buttonPulse[0] high only in cycle 13-14; buttonLevel[0] high from 13.
REQ-031 Raw ch1 pulse high for one sample only -> all outputs for ch1 remain 0.
REQ-032 Raw ch2 held 160 cycles, defaults -> one buttonPulse, one longPulse 100 cycles after it, then repeatPulse every 25 cycles (2 pulses) before release.
REQ-033 Held ch0 drops low for 1 sample at cycle 50 of PRESSED -> no IDLE transition, no second buttonPulse, longPulse delayed by exactly 1 cycle.
REQ-034 All three raws rise on the same edge -> buttonPulse = 3'b111 for one cycle.
REQ-035 Reset asserted 1 cycle while ch1 in PRESS_WAIT, raw kept high -> outputs 0 during reset, buttonPulse[1] 3 edges after reset deasserts.

Source files
------------

// File: rtl/button_conditioner.sv
// Three-channel push-button conditioner: two-flop synchronizer, debounce, and
// press / long-press / auto-repeat pulse generation with one independent FSM per channel.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES   = 2,
  parameter int unsigned LONG_PRESS_CYCLES = 100,
  parameter int unsigned REPEAT_CYCLES     = 25
) (
  input  logic       clockSignal,
  input  logic       reset,
  input  logic       startOrStopRaw,
  input  logic       splitOrResetRaw,
  input  logic       modeInputRaw,
  output logic [2:0] buttonLevel,
  output logic [2:0] buttonPulse,
  output logic [2:0] longPulse,
  output logic [2:0] repeatPulse
);

  localparam logic [7:0]  DB_LAST   = 8'(DEBOUNCE_CYCLES);
  localparam logic [15:0] LONG_LAST = 16'(LONG_PRESS_CYCLES);
  localparam logic [15:0] REP_LAST  = 16'(REPEAT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    HELD,
    RELEASE_WAIT
  } state_e;

  logic [2:0] raw_w;
  assign raw_w = {modeInputRaw, splitOrResetRaw, startOrStopRaw};

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    logic        sync1_q, sync2_q;
    state_e      state_q;
    logic        from_held_q;
    logic [7:0]  db_q;
    logic [15:0] hold_q, rpt_q;
    logic        level_q, press_q, long_q, rpt_pulse_q;
    logic [7:0]  db_d;
    logic [15:0] hold_d, rpt_d;
    logic        in_pressed;

    assign db_d   = db_q + 8'd1;
    assign hold_d = hold_q + 16'd1;
    assign rpt_d  = rpt_q + 16'd1;
    // RELEASE_WAIT keeps counting on behalf of whichever state it came from.
    assign in_pressed = (state_q == PRESSED) || ((state_q == RELEASE_WAIT) && !from_held_q);

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // in this block sees the pre-edge values of its neighbours.
    always_ff @(posedge clockSignal) begin
      if (reset) begin
        // NOTE: the synchronizer flops are reset too, so a held button is
        // re-debounced from scratch once reset drops.
        sync1_q     <= 1'b0;
        sync2_q     <= 1'b0;
        state_q     <= IDLE;
        from_held_q <= 1'b0;
        db_q        <= '0;
        hold_q      <= '0;
        rpt_q       <= '0;
        level_q     <= 1'b0;
        press_q     <= 1'b0;
        long_q      <= 1'b0;
        rpt_pulse_q <= 1'b0;
      end else begin
        sync1_q     <= raw_w[ch];
        sync2_q     <= sync1_q;
        press_q     <= 1'b0;
        long_q      <= 1'b0;
        rpt_pulse_q <= 1'b0;
        case (state_q)
          IDLE, PRESS_WAIT: begin
            if (!sync2_q) begin
              state_q <= IDLE;
            end else if ((state_q == IDLE) && (DB_LAST != 8'd1)) begin
              state_q <= PRESS_WAIT;
              db_q    <= 8'd1;
            end else if ((state_q == IDLE) || (db_d == DB_LAST)) begin
              state_q     <= PRESSED;
              from_held_q <= 1'b0;
              level_q     <= 1'b1;
              press_q     <= 1'b1;
              hold_q      <= '0;
            end else begin
              db_q <= db_d;
            end
          end
          PRESSED, HELD, RELEASE_WAIT: begin
            if (sync2_q) begin
              if (in_pressed) begin
                if (hold_d == LONG_LAST) begin
                  state_q     <= HELD;
                  from_held_q <= 1'b1;
                  long_q      <= 1'b1;
                  rpt_q       <= '0;
                end else begin
                  state_q <= PRESSED;
                  hold_q  <= hold_d;
                end
              end else begin
                state_q <= HELD;
                if (rpt_d == REP_LAST) begin
                  rpt_pulse_q <= 1'b1;
                  rpt_q       <= '0;
                end else begin
                  rpt_q <= rpt_d;
                end
              end
            end else if ((state_q == RELEASE_WAIT) ? (db_d == DB_LAST) : (DB_LAST == 8'd1)) begin
              state_q <= IDLE;
              level_q <= 1'b0;
            end else if (state_q == RELEASE_WAIT) begin
              db_q <= db_d;
            end else begin
              state_q <= RELEASE_WAIT;
              db_q    <= 8'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end

    assign buttonLevel[ch] = level_q;
    assign buttonPulse[ch] = press_q;
    assign longPulse[ch]   = long_q;
    assign repeatPulse[ch] = rpt_pulse_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a window/activity-count reference model
// predicts every cycle's outputs, and a monitor compares them against the DUT.
module tb_button_conditioner;

  localparam int DB   = 2;
  localparam int LONG = 100;
  localparam int REP  = 25;
  localparam int MAXC = 4000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] raw = 3'b000;
  logic [2:0] lvl, bp, lp, rp;

  button_conditioner #(
    .DEBOUNCE_CYCLES  (DB),
    .LONG_PRESS_CYCLES(LONG),
    .REPEAT_CYCLES    (REP)
  ) dut (
    .clockSignal    (clk),
    .reset          (rst),
    .startOrStopRaw (raw[0]),
    .splitOrResetRaw(raw[1]),
    .modeInputRaw   (raw[2]),
    .buttonLevel    (lvl),
    .buttonPulse    (bp),
    .longPulse      (lp),
    .repeatPulse    (rp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] lvl;
    logic [2:0] bp;
    logic [2:0] lp;
    logic [2:0] rp;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] raw_a[MAXC];
  logic       rst_a[MAXC];
  int         t = 0;
  int         mon_edge = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  bit m_level[3];
  int m_act[3];

  int cnt_bp[3], cnt_lp[3], cnt_rp[3], cnt_lvl[3];
  int last_bp[3], last_lp[3], last_rp[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (edge %0d): got %0h, expected %0h", name, mon_edge, act, exp);
    end
  endtask

  // Synchronized sample the FSM sees at edge e: raw from two edges earlier,
  // forced low if a reset cleared the synchronizer in between.
  function automatic bit samp(int ch, int e);
    if (e < 2) return 1'b0;
    if (rst_a[e-1] || rst_a[e-2]) return 1'b0;
    return raw_a[e-2][ch];
  endfunction

  function automatic bit window(int ch, int e, bit v);
    for (int k = 0; k < DB; k++)
      if ((e - k < 0) || (samp(ch, e - k) != v)) return 1'b0;
    return 1'b1;
  endfunction

  // Level flips after DB identical opposite samples; the activity count is the
  // number of high samples since the press, which sets long and repeat times.
  task automatic predict(input int e, output exp_t x);
    x = '0;
    for (int c = 0; c < 3; c++) begin
      if (rst_a[e]) begin
        m_level[c] = 1'b0;
        m_act[c]   = 0;
      end else if (!m_level[c]) begin
        if (window(c, e, 1'b1)) begin
          m_level[c] = 1'b1;
          m_act[c]   = 0;
          x.bp[c]    = 1'b1;
        end
      end else if (window(c, e, 1'b0)) begin
        m_level[c] = 1'b0;
      end else if (samp(c, e)) begin
        m_act[c]++;
        if (m_act[c] == LONG) x.lp[c] = 1'b1;
        else if ((m_act[c] > LONG) && (((m_act[c] - LONG) % REP) == 0)) x.rp[c] = 1'b1;
      end
      x.lvl[c] = m_level[c];
    end
  endtask

  task automatic step(input logic [2:0] r, input logic rs);
    exp_t x;
    @(negedge clk);
    if (t >= MAXC) begin
      $display("FAIL stimulus_overflow: edge %0d exceeds table size %0d", t, MAXC);
      $fatal(1, "stimulus table overflow");
    end
    raw      = r;
    rst      = rs;
    raw_a[t] = r;
    rst_a[t] = rs;
    predict(t, x);
    exp_q.push_back(x);
    t++;
  endtask

  task automatic hold(input logic [2:0] r, input int n);
    for (int i = 0; i < n; i++) step(r, 1'b0);
  endtask

  task automatic drain();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_counts();
    for (int c = 0; c < 3; c++) begin
      cnt_bp[c] = 0; cnt_lp[c] = 0; cnt_rp[c] = 0; cnt_lvl[c] = 0;
      last_bp[c] = -1; last_lp[c] = -1; last_rp[c] = -1;
    end
  endtask

  always begin : monitor
    exp_t x;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      check("buttonLevel", 32'(lvl), 32'(x.lvl));
      check("buttonPulse", 32'(bp), 32'(x.bp));
      check("longPulse", 32'(lp), 32'(x.lp));
      check("repeatPulse", 32'(rp), 32'(x.rp));
      for (int c = 0; c < 3; c++) begin
        if (bp[c] === 1'b1) begin cnt_bp[c]++; last_bp[c] = mon_edge; end
        if (lp[c] === 1'b1) begin cnt_lp[c]++; last_lp[c] = mon_edge; end
        if (rp[c] === 1'b1) begin cnt_rp[c]++; last_rp[c] = mon_edge; end
        if (lvl[c] === 1'b1) cnt_lvl[c]++;
      end
      mon_edge++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", t);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int         e;
    int         rem[3];
    logic [2:0] cur;

    for (int c = 0; c < 3; c++) begin m_level[c] = 1'b0; m_act[c] = 0; end
    clear_counts();

    repeat (3) step(3'b000, 1'b1);
    hold(3'b000, 5);
    drain();
    check("reset_outputs_zero", 32'({lvl, bp, lp, rp}), 32'd0);

    // Channel 0 plain press: pulse exactly three edges after raw rises.
    clear_counts();
    e = t;
    hold(3'b001, 12);
    hold(3'b000, 10);
    drain();
    check("ch0_press_count", 32'(cnt_bp[0]), 32'd1);
    check("ch0_press_edge", 32'(last_bp[0]), 32'(e + 3));
    check("ch0_level_cycles", 32'(cnt_lvl[0]), 32'd12);

    // Channel 1 single-sample glitch is ignored.
    clear_counts();
    hold(3'b010, 1);
    hold(3'b000, 8);
    drain();
    check("ch1_glitch_press", 32'(cnt_bp[1]), 32'd0);
    check("ch1_glitch_level", 32'(cnt_lvl[1]), 32'd0);

    // Channel 2 held 160 cycles: press, long, two repeats.
    clear_counts();
    e = t;
    hold(3'b100, 160);
    hold(3'b000, 10);
    drain();
    check("ch2_press_count", 32'(cnt_bp[2]), 32'd1);
    check("ch2_long_count", 32'(cnt_lp[2]), 32'd1);
    check("ch2_long_edge", 32'(last_lp[2]), 32'(e + 103));
    check("ch2_repeat_count", 32'(cnt_rp[2]), 32'd2);
    check("ch2_last_repeat_edge", 32'(last_rp[2]), 32'(e + 153));

    // Channel 0 drops for one sample 50 cycles into PRESSED: long pulse one cycle late.
    clear_counts();
    e = t;
    hold(3'b001, 51);
    hold(3'b000, 1);
    hold(3'b001, 70);
    hold(3'b000, 10);
    drain();
    check("ch0_bounce_press_count", 32'(cnt_bp[0]), 32'd1);
    check("ch0_bounce_long_edge", 32'(last_lp[0]), 32'(e + 104));

    // All three channels rise together.
    clear_counts();
    e = t;
    hold(3'b111, 6);
    hold(3'b000, 6);
    drain();
    for (int c = 0; c < 3; c++) check("all_press_edge", 32'(last_bp[c]), 32'(e + 3));

    // Reset for one cycle while channel 1 is in PRESS_WAIT; raw kept high.
    clear_counts();
    e = t;
    hold(3'b010, 3);
    step(3'b010, 1'b1);
    hold(3'b010, 8);
    hold(3'b000, 8);
    drain();
    check("ch1_reset_press_count", 32'(cnt_bp[1]), 32'd1);
    check("ch1_reset_press_edge", 32'(last_bp[1]), 32'(e + 7));

    // Randomized run: per-channel mix of short glitches and long holds, rare resets.
    cur = 3'b000;
    for (int c = 0; c < 3; c++) rem[c] = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 3; c++) begin
        if (rem[c] == 0) begin
          cur[c] = ~cur[c];
          rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                : int'($urandom_range(4, 180));
        end
        rem[c]--;
      end
      step(cur, ($urandom_range(0, 399) == 0));
    end
    hold(3'b000, 10);
    drain();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
